// File: rtl/trigger_det.sv
// Start/stop control for the stopwatch: synchronises a push-button trigger,
// detects its rising edge and sequences count_init / count_enb / latch_count.
module trigger_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic sys_clk,
    input  logic reset_n,
    input  logic trigger_in,
    output logic latch_count,
    output logic count_enb,
    output logic count_init
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INIT    = 3'd1,
        RUN     = 3'd2,
        LATCH   = 3'd3,
        STOPPED = 3'd4
    } state_t;

    logic [SYNC_STAGES-1:0] sync_chain_q;
    logic                   sync_q;
    logic                   prev_q;
    logic                   rise;

    state_t state_q, state_d;
    logic   count_init_q, count_enb_q, latch_count_q;

    // Metastability chain; the newest sample enters at bit 0.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_chain_q <= '0;
            prev_q       <= 1'b0;
        end else begin
            sync_chain_q <= {sync_chain_q[SYNC_STAGES-2:0], trigger_in};
            prev_q       <= sync_q;
        end
    end

    assign sync_q = sync_chain_q[SYNC_STAGES-1];
    assign rise   = sync_q & ~prev_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (rise) state_d = INIT;
            INIT:    state_d = RUN;
            RUN:     if (rise) state_d = LATCH;
            LATCH:   state_d = STOPPED;
            STOPPED: if (rise) state_d = INIT;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every strobe leaves a flop.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            count_init_q  <= 1'b0;
            count_enb_q   <= 1'b0;
            latch_count_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_init_q  <= (state_d == INIT);
            count_enb_q   <= (state_d == RUN);
            latch_count_q <= (state_d == LATCH);
        end
    end

    assign count_init  = count_init_q;
    assign count_enb   = count_enb_q;
    assign latch_count = latch_count_q;

endmodule

// File: tb/tb_trigger_det.sv
// Self-checking bench for trigger_det: timed scenario, vector table,
// hand-written corner cases and randomized traffic against an abstract model.
module tb_trigger_det;

    localparam int S = 2;

    logic sys_clk;
    logic reset_n;
    logic trigger_in;
    logic latch_count, count_enb, count_init;

    int errors = 0;
    int checks = 0;

    trigger_det #(.SYNC_STAGES(S)) dut (
        .sys_clk     (sys_clk),
        .reset_n     (reset_n),
        .trigger_in  (trigger_in),
        .latch_count (latch_count),
        .count_enb   (count_enb),
        .count_init  (count_init)
    );

    initial sys_clk = 1'b0;
    always #20 sys_clk = ~sys_clk;

    typedef struct packed {
        logic       trig;
        logic [2:0] exp_out; // {count_init, count_enb, latch_count}
    } vec_t;

    function automatic logic [2:0] outs();
        return {count_init, count_enb, latch_count};
    endfunction

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {init,enb,latch}=%b expected %b at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: {init,enb,latch}=%b at %0t", name, act, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: %0d at %0t", name, act, $time);
        end
    endtask

    task automatic wait_until(input time t);
        if (t > $time) #(t - $time);
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        reset_n    = 1'b0;
        trigger_in = 1'b0;
        repeat (2) @(negedge sys_clk);
        reset_n = 1'b1;
    endtask

    vec_t tbl [13];

    initial begin
        int   inits, latches;
        logic seen_init, seen_latch;
        logic hist [$];
        int   acc_cnt, last_acc;
        logic rise_m;
        logic [2:0] exp_m;

        // ---------------- timed scenario (edges at 20, 60, ...) ----------------
        reset_n    = 1'b0;
        trigger_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_until(10 + 20 * i);
            trigger_in = ~trigger_in;
            #5;
            check("reset_hold", outs(), 3'b000);
        end
        wait_until(80);  trigger_in = 1'b0;
        wait_until(90);  reset_n = 1'b1;
        wait_until(110); check("after_release", outs(), 3'b000);
        wait_until(120); trigger_in = 1'b1;
        wait_until(160); trigger_in = 1'b0;
        wait_until(200); check("start_pre", outs(), 3'b000);
        wait_until(240); check("start_init", outs(), 3'b100);
        wait_until(280); check("start_run", outs(), 3'b010);
        wait_until(400); check("run_steady", outs(), 3'b010);
        trigger_in = 1'b1;
        wait_until(440); trigger_in = 1'b0;
        wait_until(480); check("stop_pre", outs(), 3'b010);
        wait_until(520); check("stop_latch", outs(), 3'b001);
        wait_until(560); check("stopped", outs(), 3'b000);
        wait_until(640); trigger_in = 1'b1;
        wait_until(680); trigger_in = 1'b0;
        wait_until(720); check("restart_pre", outs(), 3'b000);
        wait_until(760); check("restart_init", outs(), 3'b100);
        wait_until(800); check("restart_run", outs(), 3'b010);

        // ---------------- vector table, one entry per clock ----------------
        tbl[0]  = '{1'b0, 3'b000};
        tbl[1]  = '{1'b1, 3'b000};
        tbl[2]  = '{1'b0, 3'b000};
        tbl[3]  = '{1'b0, 3'b100};
        tbl[4]  = '{1'b0, 3'b010};
        tbl[5]  = '{1'b1, 3'b010};
        tbl[6]  = '{1'b1, 3'b010};
        tbl[7]  = '{1'b0, 3'b001};
        tbl[8]  = '{1'b0, 3'b000};
        tbl[9]  = '{1'b1, 3'b000};
        tbl[10] = '{1'b0, 3'b000};
        tbl[11] = '{1'b0, 3'b100};
        tbl[12] = '{1'b0, 3'b010};
        do_reset();
        for (int i = 0; i < 13; i++) begin
            trigger_in = tbl[i].trig;
            @(posedge sys_clk);
            @(negedge sys_clk);
            check($sformatf("table[%0d]", i), outs(), tbl[i].exp_out);
        end

        // ---------------- held trigger: one start only ----------------
        do_reset();
        inits = 0; latches = 0;
        for (int i = 0; i < 16; i++) begin
            trigger_in = (i < 10);
            @(posedge sys_clk);
            @(negedge sys_clk);
            if (count_init) inits++;
            if (latch_count) latches++;
        end
        check_int("held_init_count", inits, 1);
        check_int("held_latch_count", latches, 0);
        check("held_running", outs(), 3'b010);

        // ---------------- asynchronous reset while running ----------------
        #5 reset_n = 1'b0;
        #1 check("async_reset_run", outs(), 3'b000);
        @(negedge sys_clk);
        reset_n    = 1'b1;
        trigger_in = 1'b1;
        repeat (2) @(negedge sys_clk);
        trigger_in = 1'b0;
        seen_init = 1'b0; seen_latch = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge sys_clk);
            if (count_init) seen_init = 1'b1;
            if (latch_count) seen_latch = 1'b1;
        end
        check_int("post_reset_init", int'(seen_init), 1);
        check_int("post_reset_latch", int'(seen_latch), 0);

        // ---------------- randomized traffic vs. abstract model ----------------
        // Model: the sample taken at edge n-S, preceded by a low at n-S-1, is an
        // accepted trigger at edge n (unless it lands on a strobe cycle).
        // Odd-numbered accepted triggers start, even ones stop.
        do_reset();
        hist.delete();
        for (int i = 0; i <= S; i++) hist.push_back(1'b0);
        acc_cnt  = 0;
        last_acc = -10;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) trigger_in = ~trigger_in;
            hist.push_back(trigger_in);
            @(posedge sys_clk);
            rise_m = hist[hist.size()-1-S] & ~hist[hist.size()-2-S];
            if (rise_m && !(acc_cnt > 0 && n == last_acc + 1)) begin
                acc_cnt++;
                last_acc = n;
            end
            if (acc_cnt == 0)
                exp_m = 3'b000;
            else if (n == last_acc)
                exp_m = (acc_cnt % 2 == 1) ? 3'b100 : 3'b001;
            else
                exp_m = (acc_cnt % 2 == 1) ? 3'b010 : 3'b000;
            @(negedge sys_clk);
            check($sformatf("rand[%0d]", n), outs(), exp_m);
        end
        check_int("rand_triggers_seen", int'(acc_cnt > 4), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
